// File: rtl/keypad_scan_if.sv
// Keypad-side and control-side signals of the charge-phone keypad scanner.
// The master side drives the columns and the decoded key outputs.
interface keypad_scan_if;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic       startSet;
  logic [4:0] num;
  logic       start;
  logic       clear;
  logic       enter;

  modport master (
    input  row_n,
    output col_n, startSet, num, start, clear, enter
  );

  modport slave (
    output row_n,
    input  col_n, startSet, num, start, clear, enter
  );
endinterface

// File: rtl/keypad_scan.sv
// 4x4 active-low keypad scanner: synchronises rows, scans columns, debounces whole
// frames and emits one startSet strobe plus decoded key per accepted press.
module keypad_scan #(
  parameter int unsigned SCAN_DIV   = 4,
  parameter int unsigned DEBOUNCE   = 3,
  parameter int unsigned STROBE_LEN = 5
) (
  input  logic          CLK,
  input  logic          RST,
  keypad_scan_if.master kp
);

  localparam int unsigned SlotW = $clog2(SCAN_DIV);
  localparam int unsigned CntW  = $clog2(DEBOUNCE + 1);
  localparam int unsigned StrW  = $clog2(STROBE_LEN + 1);

  typedef enum logic [1:0] {StIdle, StPressDb, StHeld, StRelDb} state_e;

  logic [3:0]       sync1_q, sync2_q;
  logic [SlotW-1:0] slot_q;
  logic [1:0]       col_q;
  // Column tag {last-clock-of-slot, column} travels alongside the row synchroniser
  // so each synced sample is attributed to the column that produced it.
  logic [2:0]       tag1_q, tag2_q;
  logic [15:0]      hits_q, hits_now;
  logic             sample, frame_done, fr_none, fr_single;
  logic [3:0]       fr_code;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [3:0]       cand_q;
  logic             strobe_q;
  logic [StrW-1:0]  str_cnt_q;
  logic [3:0]       num_q;
  logic             start_q, clear_q, enter_q;

  logic             key_valid, key_digit;
  logic [3:0]       key_num;
  logic [2:0]       key_flag;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
      slot_q  <= '0;
      col_q   <= '0;
      tag1_q  <= '0;
      tag2_q  <= '0;
      hits_q  <= '0;
    end else begin
      sync1_q <= kp.row_n;
      sync2_q <= sync1_q;
      tag1_q  <= {slot_q == SlotW'(SCAN_DIV - 1), col_q};
      tag2_q  <= tag1_q;
      if (slot_q == SlotW'(SCAN_DIV - 1)) begin
        slot_q <= '0;
        col_q  <= col_q + 2'd1;
      end else begin
        slot_q <= slot_q + SlotW'(1);
      end
      if (sample) hits_q <= frame_done ? '0 : hits_now;
    end
  end

  always_comb begin
    sample     = tag2_q[2];
    frame_done = sample && (tag2_q[1:0] == 2'd3);
    hits_now   = hits_q;
    if (sample) begin
      for (int r = 0; r < 4; r++) begin
        if (!sync2_q[r]) hits_now[r*4 + int'(tag2_q[1:0])] = 1'b1;
      end
    end
    fr_none   = (hits_now == '0);
    fr_single = $onehot(hits_now);
    fr_code   = '0;
    for (int i = 0; i < 16; i++) begin
      if (hits_now[i]) fr_code = 4'(i);
    end
  end

  // Row 3 holds '*', '0', '#' and an unused key; only '0' produces output.
  always_comb begin
    key_valid = 1'b0;
    key_digit = 1'b0;
    key_num   = '0;
    key_flag  = '0;
    if (cand_q[3:2] != 2'd3) begin
      key_valid = 1'b1;
      if (cand_q[1:0] != 2'd3) begin
        key_digit = 1'b1;
        key_num   = 4'(cand_q[3:2]) * 4'd3 + 4'(cand_q[1:0]) + 4'd1;
      end else begin
        key_flag = 3'b100 >> cand_q[3:2];
      end
    end else if (cand_q[1:0] == 2'd1) begin
      key_valid = 1'b1;
      key_digit = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      cand_q    <= '0;
      strobe_q  <= 1'b0;
      str_cnt_q <= '0;
      num_q     <= '0;
      start_q   <= 1'b0;
      clear_q   <= 1'b0;
      enter_q   <= 1'b0;
    end else begin
      if (strobe_q) begin
        if (str_cnt_q == StrW'(STROBE_LEN - 1)) strobe_q <= 1'b0;
        else str_cnt_q <= str_cnt_q + StrW'(1);
      end
      if (frame_done) begin
        unique case (state_q)
          StIdle: begin
            if (fr_single) begin
              state_q <= StPressDb;
              cand_q  <= fr_code;
              cnt_q   <= CntW'(1);
            end
          end
          StPressDb: begin
            if (fr_single && fr_code == cand_q) begin
              if (cnt_q >= CntW'(DEBOUNCE - 1)) begin
                state_q <= StHeld;
                cnt_q   <= '0;
                if (key_valid) begin
                  strobe_q  <= 1'b1;
                  str_cnt_q <= '0;
                  if (key_digit) num_q <= key_num;
                  {start_q, clear_q, enter_q} <= key_flag;
                end
              end else begin
                cnt_q <= cnt_q + CntW'(1);
              end
            end else if (fr_single) begin
              cand_q <= fr_code;
              cnt_q  <= CntW'(1);
            end else begin
              state_q <= StIdle;
              cnt_q   <= '0;
            end
          end
          StHeld: begin
            if (fr_none) begin
              state_q <= StRelDb;
              cnt_q   <= CntW'(1);
            end
          end
          StRelDb: begin
            if (!fr_none) begin
              state_q <= StHeld;
              cnt_q   <= '0;
            end else if (cnt_q >= CntW'(DEBOUNCE - 1)) begin
              state_q <= StIdle;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign kp.col_n    = ~(4'b0001 << col_q);
  assign kp.startSet = strobe_q;
  assign kp.num      = {1'b0, num_q};
  assign kp.start    = start_q;
  assign kp.clear    = clear_q;
  assign kp.enter    = enter_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a behavioural 4x4 keypad model and a strobe
// monitor; expected values are hand-derived from the key layout.
module tb_keypad_scan;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] pressed = '0;
  logic [3:0]  rn;

  keypad_scan_if kp ();

  keypad_scan #(
    .SCAN_DIV  (2),
    .DEBOUNCE  (2),
    .STROBE_LEN(5)
  ) u_dut (
    .CLK(CLK),
    .RST(RST),
    .kp (kp)
  );

  always #5 CLK = ~CLK;

  // Pressed key at (r,c) pulls row r low while column c is driven low.
  always_comb begin
    rn = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !kp.col_n[c]) rn[r] = 1'b0;
      end
    end
  end
  assign kp.row_n = rn;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  int pulses = 0, rise_cyc = 0, width = 0, last_w = 0;
  bit prev = 1'b0;
  always @(negedge CLK) begin
    if (kp.startSet) begin
      if (!prev) begin
        pulses++;
        rise_cyc = cyc;
        width = 1;
      end else begin
        width++;
      end
    end else if (prev) begin
      last_w = width;
    end
    prev = kp.startSet;
  end

  int n_pass = 0, n_chk = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic hold_key(input logic [15:0] keys, input int n);
    pressed = keys;
    tick(n);
  endtask

  task automatic release_all();
    pressed = '0;
    tick(100);
  endtask

  function automatic int flags();
    return int'({kp.start, kp.clear, kp.enter});
  endfunction

  int base, p, k;

  initial begin
    // 1. reset and idle
    RST = 1'b1;
    tick(2);
    check("rst_col_n", int'(kp.col_n), 4'b1110);
    check("rst_startSet", int'(kp.startSet), 0);
    check("rst_num", int'(kp.num), 0);
    check("rst_flags", flags(), 0);
    RST = 1'b0;
    base = pulses;
    tick(200);
    check("idle_no_strobe", pulses - base, 0);

    // 2. hold '5', then '0'
    base = pulses;
    p = cyc;
    hold_key(16'h0020, 200);
    check("k5_pulses", pulses - base, 1);
    check("k5_width", last_w, 5);
    check("k5_num", int'(kp.num), 5);
    check("k5_flags", flags(), 0);
    check("k5_latency_le27", (rise_cyc - p <= 27) ? 1 : 0, 1);
    release_all();
    base = pulses;
    hold_key(16'h2000, 150);
    check("k0_pulses", pulses - base, 1);
    check("k0_num", int'(kp.num), 0);
    release_all();

    // 3. bouncing '3' then steady hold, then short release glitch
    base = pulses;
    for (int i = 0; i < 14; i++) begin
      pressed[2] = ~pressed[2];
      tick(3);
    end
    hold_key(16'h0004, 150);
    check("k3_pulses", pulses - base, 1);
    check("k3_num", int'(kp.num), 3);
    base = pulses;
    k = 0;
    while (kp.col_n != 4'b0111 && k < 20) begin
      tick(1);
      k++;
    end
    check("col3_seen", (k < 20) ? 1 : 0, 1);
    pressed = '0;
    tick(10);
    hold_key(16'h0004, 100);
    check("glitch_no_pulse", pulses - base, 0);
    release_all();

    // 4. function keys and ignored keys
    hold_key(16'h0002, 150);
    check("k2_num", int'(kp.num), 2);
    release_all();
    base = pulses;
    hold_key(16'h0008, 150);
    check("start_pulses", pulses - base, 1);
    check("start_flags", flags(), 3'b100);
    check("start_num", int'(kp.num), 2);
    release_all();
    base = pulses;
    hold_key(16'h0080, 150);
    check("clear_pulses", pulses - base, 1);
    check("clear_flags", flags(), 3'b010);
    release_all();
    base = pulses;
    hold_key(16'h0800, 150);
    check("enter_pulses", pulses - base, 1);
    check("enter_flags", flags(), 3'b001);
    release_all();
    base = pulses;
    hold_key(16'h1000, 150);
    check("star_pulses", pulses - base, 0);
    check("star_flags", flags(), 3'b001);
    check("star_num", int'(kp.num), 2);
    release_all();
    base = pulses;
    hold_key(16'h4000, 150);
    check("hash_pulses", pulses - base, 0);
    check("hash_flags", flags(), 3'b001);
    release_all();

    // 5. two keys together, then one released
    base = pulses;
    hold_key(16'h0003, 150);
    check("multi_no_pulse", pulses - base, 0);
    hold_key(16'h0002, 150);
    check("multi_then_2_pulses", pulses - base, 1);
    check("multi_then_2_num", int'(kp.num), 2);
    check("multi_then_2_flags", flags(), 0);
    release_all();

    // 6. reset in the middle of the '7' strobe
    pressed = 16'h0100;
    k = 0;
    while (!kp.startSet && k < 60) begin
      tick(1);
      k++;
    end
    check("k7_strobe_seen", (k < 60) ? 1 : 0, 1);
    tick(2);
    RST = 1'b1;
    tick(1);
    check("midrst_startSet", int'(kp.startSet), 0);
    check("midrst_num", int'(kp.num), 0);
    check("midrst_col_n", int'(kp.col_n), 4'b1110);
    RST = 1'b0;
    base = pulses;
    tick(150);
    check("k7_repulse", pulses - base, 1);
    check("k7_num", int'(kp.num), 7);
    check("k7_width", last_w, 5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
